// File: rtl/phy_rx_lane.sv
// Single-lane serial receiver: recovers byte alignment from the comma symbol,
// locks after N_COMMA aligned commas, then emits each data byte with a valid flag.
module phy_rx_lane #(
    parameter logic [7:0] COMMA   = 8'hBC,
    parameter int         N_COMMA = 4
) (
    input  logic       clk_8f,
    input  logic       reset_L,
    input  logic       enable,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] N_LOCK = 4'(N_COMMA);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] sr_r;
    logic [7:0] nxt_s;
    logic [2:0] bit_cnt_r;
    logic [2:0] bit_cnt_nxt_s;
    logic [3:0] comma_cnt_r;
    logic [3:0] comma_cnt_nxt_s;
    logic [3:0] comma_inc_s;
    logic       is_comma_s;
    logic       boundary_s;
    logic [7:0] data_nxt_s;
    logic       valid_nxt_s;
    logic       strobe_nxt_s;
    logic       active_nxt_s;

    // Byte checks look at the window that includes the bit arriving on this edge.
    assign nxt_s       = {sr_r[6:0], rx_in};
    assign is_comma_s  = (nxt_s == COMMA);
    assign boundary_s  = (bit_cnt_r == 3'd7);
    assign comma_inc_s = comma_cnt_r + 4'd1;

    // State register.
    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            state_r <= SEARCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a dropped enable always returns to search.
    always_comb begin
        state_nxt_s = state_r;
        if (!enable) begin
            state_nxt_s = SEARCH;
        end else begin
            case (state_r)
                SEARCH: begin
                    if (is_comma_s) begin
                        state_nxt_s = (N_COMMA == 1) ? ACTIVE : ALIGN;
                    end else begin
                        state_nxt_s = SEARCH;
                    end
                end
                ALIGN: begin
                    if (!boundary_s) begin
                        state_nxt_s = ALIGN;
                    end else if (!is_comma_s) begin
                        state_nxt_s = SEARCH;
                    end else if (comma_inc_s == N_LOCK) begin
                        state_nxt_s = ACTIVE;
                    end else begin
                        state_nxt_s = ALIGN;
                    end
                end
                ACTIVE:  state_nxt_s = ACTIVE;
                default: state_nxt_s = SEARCH;
            endcase
        end
    end

    // Next values for counters and registered outputs.
    always_comb begin
        bit_cnt_nxt_s   = bit_cnt_r;
        comma_cnt_nxt_s = comma_cnt_r;
        data_nxt_s      = data_out;
        valid_nxt_s     = valid_out;
        strobe_nxt_s    = 1'b0;
        active_nxt_s    = (state_nxt_s == ACTIVE);
        if (!enable) begin
            comma_cnt_nxt_s = 4'd0;
            valid_nxt_s     = 1'b0;
        end else begin
            case (state_r)
                SEARCH: begin
                    if (is_comma_s) begin
                        bit_cnt_nxt_s   = 3'd0;
                        comma_cnt_nxt_s = 4'd1;
                    end else begin
                        comma_cnt_nxt_s = comma_cnt_r;
                    end
                end
                ALIGN: begin
                    bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    if (boundary_s) begin
                        comma_cnt_nxt_s = is_comma_s ? comma_inc_s : 4'd0;
                    end else begin
                        comma_cnt_nxt_s = comma_cnt_r;
                    end
                end
                ACTIVE: begin
                    bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    if (boundary_s) begin
                        strobe_nxt_s = 1'b1;
                        if (!is_comma_s) begin
                            data_nxt_s  = nxt_s;
                            valid_nxt_s = 1'b1;
                        end else begin
                            valid_nxt_s = 1'b0;
                        end
                    end else begin
                        strobe_nxt_s = 1'b0;
                    end
                end
                default: begin
                    comma_cnt_nxt_s = 4'd0;
                    valid_nxt_s     = 1'b0;
                end
            endcase
        end
    end

    // Shift register, counters and output registers.
    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            sr_r        <= 8'h00;
            bit_cnt_r   <= 3'd0;
            comma_cnt_r <= 4'd0;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            sr_r        <= nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            comma_cnt_r <= comma_cnt_nxt_s;
            data_out    <= data_nxt_s;
            valid_out   <= valid_nxt_s;
            byte_strobe <= strobe_nxt_s;
            active      <= active_nxt_s;
        end
    end

endmodule

// File: tb/tb_phy_rx_lane.sv
// Directed bench for phy_rx_lane: per-cycle comparison against a bit-position
// model plus literal checks on lock timing and the received byte sequence.
module tb_phy_rx_lane;

    localparam logic [7:0] COMMA   = 8'hBC;
    localparam int         N_COMMA = 4;

    logic       clk_8f;
    logic       reset_L;
    logic       enable;
    logic       rx_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int vectors;
    int miscompares;
    logic [8:0] caps[$];

    phy_rx_lane #(.COMMA(COMMA), .N_COMMA(N_COMMA)) dut (
        .clk_8f     (clk_8f),
        .reset_L    (reset_L),
        .enable     (enable),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .byte_strobe(byte_strobe),
        .active     (active)
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    // Model: absolute bit index n; the first comma found while searching sets the
    // anchor, and every 8th bit after the anchor is a byte boundary.
    typedef struct {
        logic [7:0] hist;
        logic [7:0] data;
        logic       locked;
        logic       aligning;
        logic       valid;
        logic       strobe;
        int         n;
        int         anchor;
    } model_t;

    model_t m;

    function automatic model_t model_clear();
        model_t r;
        r.hist = 8'h00; r.data = 8'h00; r.locked = 1'b0; r.aligning = 1'b0;
        r.valid = 1'b0; r.strobe = 1'b0; r.n = 0; r.anchor = 0;
        return r;
    endfunction

    function automatic model_t model_step(model_t cur, logic b, logic en);
        model_t     r;
        logic [7:0] w;
        logic       bnd;
        r        = cur;
        w        = {cur.hist[6:0], b};
        r.hist   = w;
        r.n      = cur.n + 1;
        r.strobe = 1'b0;
        bnd      = ((r.n - cur.anchor) % 8) == 0;
        if (!en) begin
            r.locked = 1'b0; r.aligning = 1'b0; r.valid = 1'b0;
        end else if (cur.locked) begin
            if (bnd) begin
                r.strobe = 1'b1;
                r.valid  = (w != COMMA);
                if (w != COMMA) r.data = w;
            end
        end else if (cur.aligning) begin
            if (bnd) begin
                if (w != COMMA) begin
                    r.aligning = 1'b0;
                end else if ((r.n - cur.anchor) / 8 + 1 == N_COMMA) begin
                    r.aligning = 1'b0; r.locked = 1'b1;
                end
            end
        end else if (w == COMMA) begin
            r.anchor = r.n;
            if (N_COMMA == 1) r.locked = 1'b1;
            else r.aligning = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) m <= model_clear();
        else m <= model_step(m, rx_in, enable);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, and capture of each byte boundary.
    initial begin
        forever begin
            @(negedge clk_8f);
            check("active", 32'(active), 32'(m.locked));
            check("valid_out", 32'(valid_out), 32'(m.valid));
            check("byte_strobe", 32'(byte_strobe), 32'(m.strobe));
            check("data_out", 32'(data_out), 32'(m.data));
            if (reset_L && byte_strobe) caps.push_back({valid_out, data_out});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic send_bit(input logic b);
        rx_in = b;
        @(negedge clk_8f);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_commas(input int k);
        for (int i = 0; i < k; i++) send_byte(COMMA);
    endtask

    task automatic drop_enable(input int k);
        enable = 1'b0;
        for (int i = 0; i < k; i++) send_bit(1'b0);
        enable = 1'b1;
    endtask

    task automatic expect_caps(input string nm, input int cnt, input logic [8:0] e0,
                               input logic [8:0] e1, input logic [8:0] e2, input logic [8:0] e3);
        logic [8:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({nm, "_count"}, 32'(caps.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < caps.size(); i++)
            check($sformatf("%s_byte%0d", nm, i), 32'(caps[i]), 32'(e[i]));
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset_L = 1'b0; enable = 1'b1; rx_in = 1'b0;
        #1;
        check("reset_outputs", {22'd0, data_out, valid_out, byte_strobe, active}, 32'd0);
        @(negedge clk_8f); @(negedge clk_8f);
        reset_L = 1'b1;
        send_byte(8'h00);

        // 1: lock on the last bit of the 4th comma, then 01,02,03
        caps.delete();
        send_commas(3);
        for (int i = 7; i >= 1; i--) send_bit(COMMA[i]);
        check("t1_active_before", 32'(active), 32'd0);
        send_bit(COMMA[0]);
        check("t1_active_lock", 32'(active), 32'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(COMMA);
        expect_caps("t1", 4, 9'h101, 9'h102, 9'h103, 9'h003);

        // 2: unaligned start
        drop_enable(8);
        caps.delete();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_commas(4);
        send_byte(8'hA5); send_byte(COMMA);
        expect_caps("t2", 2, 9'h1A5, 9'h0A5, 9'h000, 9'h000);

        // 3: broken preamble
        drop_enable(8);
        caps.delete();
        send_commas(2); send_byte(8'h55);
        check("t3_active_after55", 32'(active), 32'd0);
        send_commas(3);
        check("t3_active_3commas", 32'(active), 32'd0);
        send_commas(1);
        check("t3_active_relock", 32'(active), 32'd1);
        send_byte(8'h7E); send_byte(COMMA);
        expect_caps("t3", 2, 9'h17E, 9'h07E, 9'h000, 9'h000);

        // 4: idle insertion
        caps.delete();
        send_byte(8'h10); send_byte(COMMA);
        check("t4_idle_data", {23'd0, valid_out, data_out}, 32'h010);
        send_byte(COMMA); send_byte(8'h11);
        expect_caps("t4", 4, 9'h110, 9'h010, 9'h010, 9'h111);

        // 5: enable drop for 5 clocks
        send_byte(8'h44);
        enable = 1'b0;
        send_bit(1'b0);
        check("t5_drop", {22'd0, data_out, valid_out, byte_strobe, active}, {22'd0, 8'h44, 3'b000});
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        enable = 1'b1;
        send_byte(8'h00);
        caps.delete();
        send_commas(3);
        check("t5_active_3commas", 32'(active), 32'd0);
        send_commas(1);
        check("t5_active_relock", 32'(active), 32'd1);
        send_byte(8'h33); send_byte(COMMA);
        expect_caps("t5", 2, 9'h133, 9'h033, 9'h000, 9'h000);

        // 6: asynchronous reset after 4 bits of a data byte
        for (int i = 0; i < 4; i++) send_bit(i == 1 || i == 2);
        #2 reset_L = 1'b0;
        #1;
        check("t6_async_reset", {22'd0, data_out, valid_out, byte_strobe, active}, 32'd0);
        @(negedge clk_8f); @(negedge clk_8f);
        reset_L = 1'b1;
        send_byte(8'h00);
        caps.delete();
        send_commas(4);
        send_byte(8'h22); send_byte(COMMA);
        expect_caps("t6", 2, 9'h122, 9'h022, 9'h000, 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
